mc_ctl_fsm: RTL and testbench
=============================

// Module: mc_ctl_fsm
// PURPOSE
//  Multicycle MIPS control unit: successor to the single-cycle decoder. Sequences each
//  instruction through FETCH/DECODE/EXEC/MEM/WB states, stalls on a memory-ready handshake,
//  and adds precise exception entry for reserved instructions and N_IRQ interrupt lines.
//  Sits between IR (opCode/funct) and the multicycle datapath (PC, IR, ALUOut, EPC, Cause).
// PARAMETERS
//  N_IRQ      6   number of level-sensitive interrupt inputs (1..8)
//  MEM_HS     1   1: memory states wait for mem_ready; 0: mem_ready ignored, 1-cycle memory
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      reset, synchronous, active-high
//  opCode     in   6      IR[31:26]
//  funct      in   6      IR[5:0]
//  zero       in   1      ALU zero flag (valid in BRANCH)
//  mem_ready  in   1      memory access completes this cycle
//  irq        in   N_IRQ  interrupt requests, bit 0 highest priority
//  irq_en     in   1      global interrupt enable
//  PCWrite    out  1      PC load
//  PCSrc      out  3      000 ALU, 001 ALUOut, 010 jump tgt, 011 rs (jr), 100 exc vector
//  IorD       out  1      1: memory address from ALUOut
//  MemRead    out  1      memory read strobe
//  MemWrite   out  1      memory write strobe
//  IRWrite    out  1      IR load
//  RegWrite   out  1      register file write
//  RegDst     out  2      00 rd, 01 rt, 10 r31
//  MemToReg   out  1      write-back from MDR
//  ALUSrcA    out  2      00 PC, 01 rs, 10 shamt
//  ALUSrcB    out  2      00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALUOp      out  5      ALU operation (package encodings)
//  EPCWrite   out  1      EPC <- PC-4 (DECODE excp) or PC (FETCH irq)
//  CauseWrite out  1      Cause register load
//  ExcCode    out  5      0 interrupt, 10 reserved instruction
//  IrqId      out  3      index of serviced irq (valid with CauseWrite, ExcCode 0)
// BEHAVIOUR
//  - Reset: state<=FETCH next edge; while reset high every output is 0 (no stray MemWrite).
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD. On mem_ready (or MEM_HS=0):
//    IRWrite=1, PCWrite=1, PCSrc=000, ->DECODE; else hold FETCH with strobes asserted.
//  - Interrupt: checked on FETCH entry cycle only, before MemRead: if irq_en & |irq -> EXCP
//    with ExcCode=0, IrqId=lowest set bit; no fetch issued that cycle.
//  - DECODE: ALUSrcA=00, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Legal set =
//    add sub and or xor nor slt sll srl sra jr, addi andi ori xori lw sw beq bne j jal.
//    Illegal -> EXCP, ExcCode=10. R-type->EXEC_R; I-ALU->EXEC_I; lw/sw->ADDR; beq/bne->BRANCH;
//    j->JUMP; jal->JAL; jr->JR.
//  - EXEC_R: ALUSrcA=01 (10 for shifts), ALUSrcB=00, ALUOp per funct -> WB_R (RegDst=00).
//  - EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp per opCode -> WB_I (RegDst=01).
//  - ADDR: ALUSrcA=01, ALUSrcB=10, ADD -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD / MEM_WR: IorD=1, strobe held until mem_ready; MEM_RD->WB_MEM (RegDst=01,
//    MemToReg=1), MEM_WR->FETCH. Each WB_* state: RegWrite=1 for exactly one cycle ->FETCH.
//  - BRANCH: ALUSrcA=01, ALUSrcB=00, SUB, PCSrc=001, PCWrite=(beq&zero)|(bne&~zero) ->FETCH.
//  - JUMP: PCSrc=010, PCWrite=1. JAL: additionally RegWrite=1, RegDst=10 (r31<-PC). JR: 011.
//  - EXCP: one cycle: EPCWrite, CauseWrite, PCWrite, PCSrc=100 ->FETCH.
//  - Latency (MEM_HS=0): R/I 4, lw 5, sw 4, branch/jump 3, exception 3 (illegal) cycles.
//  - Reset mid-MEM_WR: MemWrite drops in the cycle reset rises; no write-back ever completes.
//  - irq rising during a non-FETCH state is deferred, never aborts the current instruction.
// STRUCTURE
//  - Package mc_ctl_pkg: state_t enum, opcode/funct localparams, ALUOP_* (ADD 00000,
//    SUB 00001, AND 11000, OR 11110, XOR 10110, NOR 10001, SLT 00111, SLL 01000,
//    SRL 01001, SRA 01011), PCSRC_*, EXC_INT=0, EXC_RI=10.
//  - Sub-module mc_alu_dec: combinational opCode/funct -> ALUOp + legal flag; FSM is top.
// TESTING
//  - add (op 0, funct 20), MEM_HS=0 -> IRWrite@1, RegWrite=1 RegDst=00 only at cycle 4.
//  - lw with mem_ready low 3 cycles in MEM_RD -> MemRead/IorD held 4 cycles, one RegWrite.
//  - beq zero=1 then zero=0 -> PCWrite 1 / 0 in BRANCH, PCSrc=001 both times.
//  - opCode 6'h3F -> EXCP: ExcCode=10, EPCWrite/PCWrite=1, PCSrc=100, RegWrite never 1.
//  - irq=6'b010100, irq_en=1 at FETCH -> IrqId=2 ExcCode=0; irq_en=0 -> normal fetch.
//  - reset asserted during MEM_WR -> MemWrite 0 same cycle, state FETCH after next edge.

Source files
------------

// File: rtl/mc_ctl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_ctl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StAddr, StMemRd, StMemWr,
    StWbR, StWbI, StWbMem, StBranch, StJump, StJal, StJr, StExcp
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] ALUOP_ADD = 5'b00000;
  localparam logic [4:0] ALUOP_SUB = 5'b00001;
  localparam logic [4:0] ALUOP_AND = 5'b11000;
  localparam logic [4:0] ALUOP_OR  = 5'b11110;
  localparam logic [4:0] ALUOP_XOR = 5'b10110;
  localparam logic [4:0] ALUOP_NOR = 5'b10001;
  localparam logic [4:0] ALUOP_SLT = 5'b00111;
  localparam logic [4:0] ALUOP_SLL = 5'b01000;
  localparam logic [4:0] ALUOP_SRL = 5'b01001;
  localparam logic [4:0] ALUOP_SRA = 5'b01011;

  localparam logic [2:0] PCSRC_ALU    = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_RS     = 3'b011;
  localparam logic [2:0] PCSRC_EXC    = 3'b100;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;

  // Index of the lowest set bit; bit 0 wins ties.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] id;
    id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) id = 3'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decoder: ALU operation, legality and shift flag.
module mc_alu_dec
  import mc_ctl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [4:0] alu_op_o,
  output logic       legal_o,
  output logic       shift_o
);

  always_comb begin
    alu_op_o = ALUOP_ADD;
    legal_o  = 1'b1;
    shift_o  = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_op_o = ALUOP_ADD;
          FN_SUB:  alu_op_o = ALUOP_SUB;
          FN_AND:  alu_op_o = ALUOP_AND;
          FN_OR:   alu_op_o = ALUOP_OR;
          FN_XOR:  alu_op_o = ALUOP_XOR;
          FN_NOR:  alu_op_o = ALUOP_NOR;
          FN_SLT:  alu_op_o = ALUOP_SLT;
          FN_SLL:  begin alu_op_o = ALUOP_SLL; shift_o = 1'b1; end
          FN_SRL:  begin alu_op_o = ALUOP_SRL; shift_o = 1'b1; end
          FN_SRA:  begin alu_op_o = ALUOP_SRA; shift_o = 1'b1; end
          FN_JR:   alu_op_o = ALUOP_ADD;
          default: legal_o  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J, OP_JAL: alu_op_o = ALUOP_ADD;
      OP_ANDI:         alu_op_o = ALUOP_AND;
      OP_ORI:          alu_op_o = ALUOP_OR;
      OP_XORI:         alu_op_o = ALUOP_XOR;
      OP_BEQ, OP_BNE:  alu_op_o = ALUOP_SUB;
      default:         legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctl_fsm.sv
// Multicycle MIPS control FSM with memory handshake stalls and precise
// exception entry for reserved instructions and level-sensitive interrupts.
module mc_ctl_fsm
  import mc_ctl_pkg::*;
#(
  parameter int unsigned NIrq  = 6,
  parameter bit          MemHs = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [5:0]      opcode_i,
  input  logic [5:0]      funct_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  input  logic [NIrq-1:0] irq_i,
  input  logic            irq_en_i,
  output logic            pc_write_o,
  output logic [2:0]      pc_src_o,
  output logic            iord_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            reg_write_o,
  output logic [1:0]      reg_dst_o,
  output logic            mem_to_reg_o,
  output logic [1:0]      alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [4:0]      alu_op_o,
  output logic            epc_write_o,
  output logic            cause_write_o,
  output logic [4:0]      exc_code_o,
  output logic [2:0]      irq_id_o
);

  state_t     state_q, state_d;
  logic       fetch_first_q, fetch_first_d;
  logic [4:0] exc_code_q, exc_code_d;
  logic [2:0] irq_id_q, irq_id_d;

  logic [4:0] dec_alu_op;
  logic       dec_legal, dec_shift;
  logic       mem_ok, irq_take;
  logic [7:0] irq_pad;

  mc_alu_dec u_alu_dec (
    .opcode_i (opcode_i),
    .funct_i  (funct_i),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal),
    .shift_o  (dec_shift)
  );

  assign irq_pad = 8'(irq_i);
  assign mem_ok  = !MemHs || mem_ready_i;
  // Interrupts are sampled only on the first FETCH cycle so a stalled fetch is never aborted.
  assign irq_take = (state_q == StFetch) && fetch_first_q && irq_en_i && (|irq_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StFetch;
      fetch_first_q <= 1'b1;
      exc_code_q    <= '0;
      irq_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_first_q <= fetch_first_d;
      exc_code_q    <= exc_code_d;
      irq_id_q      <= irq_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exc_code_d = exc_code_q;
    irq_id_d   = irq_id_q;
    unique case (state_q)
      StFetch: begin
        if (irq_take) begin
          state_d    = StExcp;
          exc_code_d = EXC_INT;
          irq_id_d   = lowest_set(irq_pad);
        end else if (mem_ok) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!dec_legal) begin
          state_d    = StExcp;
          exc_code_d = EXC_RI;
          irq_id_d   = '0;
        end else begin
          case (opcode_i)
            OP_RTYPE:      state_d = (funct_i == FN_JR) ? StJr : StExecR;
            OP_LW, OP_SW:  state_d = StAddr;
            OP_BEQ, OP_BNE: state_d = StBranch;
            OP_J:          state_d = StJump;
            OP_JAL:        state_d = StJal;
            default:       state_d = StExecI;
          endcase
        end
      end
      StExecR: state_d = StWbR;
      StExecI: state_d = StWbI;
      StAddr:  state_d = (opcode_i == OP_LW) ? StMemRd : StMemWr;
      StMemRd: if (mem_ok) state_d = StWbMem;
      StMemWr: if (mem_ok) state_d = StFetch;
      default: state_d = StFetch;
    endcase
    fetch_first_d = (state_d == StFetch) && (state_q != StFetch);
  end

  always_comb begin
    pc_write_o    = 1'b0;
    pc_src_o      = PCSRC_ALU;
    iord_o        = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    reg_dst_o     = 2'b00;
    mem_to_reg_o  = 1'b0;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    alu_op_o      = ALUOP_ADD;
    epc_write_o   = 1'b0;
    cause_write_o = 1'b0;
    exc_code_o    = '0;
    irq_id_o      = '0;
    if (!reset_i) begin
      unique case (state_q)
        StFetch: begin
          if (!irq_take) begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            ir_write_o  = mem_ok;
            pc_write_o  = mem_ok;
          end
        end
        StDecode: alu_src_b_o = 2'b11;
        StExecR: begin
          alu_src_a_o = dec_shift ? 2'b10 : 2'b01;
          alu_op_o    = dec_alu_op;
        end
        StExecI: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
          alu_op_o    = dec_alu_op;
        end
        StAddr: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
        end
        StMemRd: begin
          iord_o     = 1'b1;
          mem_read_o = 1'b1;
        end
        StMemWr: begin
          iord_o      = 1'b1;
          mem_write_o = 1'b1;
        end
        StWbR: reg_write_o = 1'b1;
        StWbI: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 2'b01;
        end
        StWbMem: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'b01;
          mem_to_reg_o = 1'b1;
        end
        StBranch: begin
          alu_src_a_o = 2'b01;
          alu_op_o    = ALUOP_SUB;
          pc_src_o    = PCSRC_ALUOUT;
          pc_write_o  = ((opcode_i == OP_BEQ) && zero_i) || ((opcode_i == OP_BNE) && !zero_i);
        end
        StJump: begin
          pc_src_o   = PCSRC_JUMP;
          pc_write_o = 1'b1;
        end
        StJal: begin
          pc_src_o    = PCSRC_JUMP;
          pc_write_o  = 1'b1;
          reg_write_o = 1'b1;
          reg_dst_o   = 2'b10;
        end
        StJr: begin
          pc_src_o   = PCSRC_RS;
          pc_write_o = 1'b1;
        end
        StExcp: begin
          epc_write_o   = 1'b1;
          cause_write_o = 1'b1;
          pc_write_o    = 1'b1;
          pc_src_o      = PCSRC_EXC;
          exc_code_o    = exc_code_q;
          irq_id_o      = irq_id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctl_fsm.sv
// Scoreboard bench for mc_ctl_fsm: expected per-cycle control words are queued
// as stimulus is driven and compared against the packed DUT outputs on the falling edge.
module tb_mc_ctl_fsm;

  localparam logic [4:0] A_ADD = 5'b00000;
  localparam logic [4:0] A_SUB = 5'b00001;
  localparam logic [4:0] A_OR  = 5'b11110;
  localparam logic [4:0] A_SLL = 5'b01000;

  typedef struct {
    string       tag;
    logic [30:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready, irq_en;
  logic [5:0] irq;
  logic       sel_hs0;

  logic       pcw0, iord0, mr0, mw0, irw0, rw0, m2r0, epc0, cs0;
  logic [2:0] pcs0, id0;
  logic [1:0] rd0, sa0, sb0;
  logic [4:0] alu0, exc0;
  logic       pcw1, iord1, mr1, mw1, irw1, rw1, m2r1, epc1, cs1;
  logic [2:0] pcs1, id1;
  logic [1:0] rd1, sa1, sb1;
  logic [4:0] alu1, exc1;
  logic [30:0] ctl0, ctl1;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  logic [30:0] fetch_go, fetch_wait, dec_w, wb_r, wb_i, addr_w, memrd_w, memwr_w;

  always #5 clk = ~clk;

  mc_ctl_fsm #(.NIrq(6), .MemHs(1'b0)) u_dut_hs0 (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(mem_ready), .irq_i(irq), .irq_en_i(irq_en),
    .pc_write_o(pcw0), .pc_src_o(pcs0), .iord_o(iord0), .mem_read_o(mr0),
    .mem_write_o(mw0), .ir_write_o(irw0), .reg_write_o(rw0), .reg_dst_o(rd0),
    .mem_to_reg_o(m2r0), .alu_src_a_o(sa0), .alu_src_b_o(sb0), .alu_op_o(alu0),
    .epc_write_o(epc0), .cause_write_o(cs0), .exc_code_o(exc0), .irq_id_o(id0)
  );

  mc_ctl_fsm #(.NIrq(6), .MemHs(1'b1)) u_dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(mem_ready), .irq_i(irq), .irq_en_i(irq_en),
    .pc_write_o(pcw1), .pc_src_o(pcs1), .iord_o(iord1), .mem_read_o(mr1),
    .mem_write_o(mw1), .ir_write_o(irw1), .reg_write_o(rw1), .reg_dst_o(rd1),
    .mem_to_reg_o(m2r1), .alu_src_a_o(sa1), .alu_src_b_o(sb1), .alu_op_o(alu1),
    .epc_write_o(epc1), .cause_write_o(cs1), .exc_code_o(exc1), .irq_id_o(id1)
  );

  assign ctl0 = {pcw0, pcs0, iord0, mr0, mw0, irw0, rw0, rd0, m2r0, sa0, sb0, alu0,
                 epc0, cs0, exc0, id0};
  assign ctl1 = {pcw1, pcs1, iord1, mr1, mw1, irw1, rw1, rd1, m2r1, sa1, sb1, alu1,
                 epc1, cs1, exc1, id1};

  function automatic logic [30:0] cw(
    input logic pcw, input logic [2:0] pcs, input logic iord, input logic mr, input logic mw,
    input logic irw, input logic rw, input logic [1:0] rd, input logic m2r,
    input logic [1:0] sa, input logic [1:0] sb, input logic [4:0] alu,
    input logic epc, input logic cs, input logic [4:0] exc, input logic [2:0] id);
    return {pcw, pcs, iord, mr, mw, irw, rw, rd, m2r, sa, sb, alu, epc, cs, exc, id};
  endfunction

  task automatic check_val(input string tag, input logic [30:0] got, input logic [30:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, sel_hs0 ? ctl0 : ctl1, e.exp);
    end
  end

  task automatic cyc(input string tag, input logic [30:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc("reset", 31'd0);
    reset = 1'b0;
  endtask

  task automatic fd(input string tag, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    cyc({tag, ".fetch"}, fetch_go);
    cyc({tag, ".dec"}, dec_w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fetch_go   = cw(1, 3'd0, 0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 2'd1, A_ADD, 0, 0, 5'd0, 3'd0);
    fetch_wait = cw(0, 3'd0, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, A_ADD, 0, 0, 5'd0, 3'd0);
    dec_w      = cw(0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd3, A_ADD, 0, 0, 5'd0, 3'd0);
    wb_r       = cw(0, 3'd0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0);
    wb_i       = cw(0, 3'd0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0);
    addr_w     = cw(0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd2, A_ADD, 0, 0, 5'd0, 3'd0);
    memrd_w    = cw(0, 3'd0, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0);
    memwr_w    = cw(0, 3'd0, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0);

    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    irq = '0; irq_en = 1'b0; sel_hs0 = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst_hold0", 31'd0);
    cyc("rst_hold1", 31'd0);
    reset = 1'b0;
    cyc("fetch_stall0", fetch_wait);
    cyc("fetch_stall1", fetch_wait);

    // add on the handshake-free instance with mem_ready held low
    sel_hs0 = 1'b1;
    do_reset();
    fd("add_hs0", 6'h00, 6'h20);
    cyc("add_hs0.exec", cw(0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));
    cyc("add_hs0.wb", wb_r);
    cyc("add_hs0.next", fetch_go);
    sel_hs0 = 1'b0;
    mem_ready = 1'b1;
    do_reset();

    fd("sll", 6'h00, 6'h00);
    cyc("sll.exec", cw(0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 2'd0, A_SLL, 0, 0, 5'd0, 3'd0));
    cyc("sll.wb", wb_r);
    fd("or", 6'h00, 6'h25);
    cyc("or.exec", cw(0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, A_OR, 0, 0, 5'd0, 3'd0));
    cyc("or.wb", wb_r);
    fd("ori", 6'h0D, 6'h00);
    cyc("ori.exec", cw(0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd2, A_OR, 0, 0, 5'd0, 3'd0));
    cyc("ori.wb", wb_i);

    fd("lw", 6'h23, 6'h00);
    cyc("lw.addr", addr_w);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw.memrd_wait", memrd_w);
    mem_ready = 1'b1;
    cyc("lw.memrd_done", memrd_w);
    cyc("lw.wb", cw(0, 3'd0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));

    fd("sw", 6'h2B, 6'h00);
    cyc("sw.addr", addr_w);
    cyc("sw.memwr", memwr_w);

    zero = 1'b1;
    fd("beq_z1", 6'h04, 6'h00);
    cyc("beq_z1.br", cw(1, 3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, A_SUB, 0, 0, 5'd0, 3'd0));
    zero = 1'b0;
    fd("beq_z0", 6'h04, 6'h00);
    cyc("beq_z0.br", cw(0, 3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, A_SUB, 0, 0, 5'd0, 3'd0));
    fd("bne_z0", 6'h05, 6'h00);
    cyc("bne_z0.br", cw(1, 3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, A_SUB, 0, 0, 5'd0, 3'd0));

    fd("j", 6'h02, 6'h00);
    cyc("j.jump", cw(1, 3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));
    fd("jal", 6'h03, 6'h00);
    cyc("jal.jump", cw(1, 3'd2, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));
    fd("jr", 6'h00, 6'h08);
    cyc("jr.jump", cw(1, 3'd3, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));

    fd("ri_op3f", 6'h3F, 6'h00);
    cyc("ri_op3f.excp", cw(1, 3'd4, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 1, 1, 5'd10, 3'd0));
    fd("ri_fn01", 6'h00, 6'h01);
    cyc("ri_fn01.excp", cw(1, 3'd4, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 1, 1, 5'd10, 3'd0));

    irq = 6'b010100;
    irq_en = 1'b1;
    cyc("irq.take", 31'd0);
    irq = '0;
    cyc("irq.excp", cw(1, 3'd4, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 1, 1, 5'd0, 3'd2));
    irq = 6'b010100;
    irq_en = 1'b0;
    fd("irq_off", 6'h02, 6'h00);
    cyc("irq_off.jump", cw(1, 3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));
    irq = '0;

    // irq raised mid-instruction must wait for the next fetch
    opcode = 6'h00;
    funct  = 6'h20;
    cyc("defer.fetch", fetch_go);
    irq = 6'b100001;
    irq_en = 1'b1;
    cyc("defer.dec", dec_w);
    cyc("defer.exec", cw(0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));
    cyc("defer.wb", wb_r);
    cyc("defer.take", 31'd0);
    irq = '0;
    cyc("defer.excp", cw(1, 3'd4, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 1, 1, 5'd0, 3'd0));
    irq_en = 1'b0;

    fd("sw_rst", 6'h2B, 6'h00);
    cyc("sw_rst.addr", addr_w);
    mem_ready = 1'b0;
    cyc("sw_rst.memwr", memwr_w);
    reset = 1'b1;
    cyc("sw_rst.drop", 31'd0);
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h02;
    cyc("sw_rst.fetch", fetch_go);
    cyc("sw_rst.dec", dec_w);
    cyc("sw_rst.jump", cw(1, 3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, A_ADD, 0, 0, 5'd0, 3'd0));

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
